calc_seg_display: RTL and testbench

//  Output stage of the calculator: latches the 16-bit unsigned result, converts it to
//  5 BCD digits with a sequential double-dabble, then time-multiplexes the digits onto
//  the 7-segment bus (seg_out/seg_sel). Sits between the calculator datapath and the

---
 rtl/calc_disp_pkg.sv | 42 ++++
 rtl/calc_seg_display_if.sv | 13 +
 rtl/calc_bin2bcd.sv | 73 +++++++
 rtl/calc_seg_display.sv | 74 +++++++
 tb/tb_calc_seg_display.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/calc_disp_pkg.sv
// Shared constants for the calculator display stage: digit count, segment codes, FSM encodings.
package calc_disp_pkg;

   localparam int unsigned NUM_DIGITS = 5;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
   localparam int unsigned ITER_W     = 4;
   localparam int unsigned SEG_W      = 7;

   // Active-low segment patterns {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] CONV = 1'b1;

   function automatic logic [SEG_W-1:0] seg_lut(input logic [3:0] d);
      case (d)
         4'd0:    seg_lut = SEG_0;
         4'd1:    seg_lut = SEG_1;
         4'd2:    seg_lut = SEG_2;
         4'd3:    seg_lut = SEG_3;
         4'd4:    seg_lut = SEG_4;
         4'd5:    seg_lut = SEG_5;
         4'd6:    seg_lut = SEG_6;
         4'd7:    seg_lut = SEG_7;
         4'd8:    seg_lut = SEG_8;
         4'd9:    seg_lut = SEG_9;
         default: seg_lut = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/calc_seg_display_if.sv
// Datapath-to-display interface: load/value handshake plus busy and the 7-segment pins.
interface calc_seg_display_if;
   import calc_disp_pkg::*;

   logic                  load;
   logic [DATA_W-1:0]     value;
   logic                  busy;
   logic [SEG_W-1:0]      seg_out;
   logic [NUM_DIGITS-1:0] seg_sel;

   modport master (output load, output value, input busy, input seg_out, input seg_sel);
   modport slave  (input load, input value, output busy, output seg_out, output seg_sel);
endinterface

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble: one add-3/shift iteration per clock, 16 iterations per value.
module calc_bin2bcd
   import calc_disp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] value,
   output logic              busy,
   output logic [BCD_W-1:0]  bcd_c,
   output logic              bcd_valid_c
);

   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [BCD_W-1:0]  adj;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         bcd_q   <= '0;
         iter_q  <= '0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         busy    <= (state_d == CONV);
      end
   end

   // Next state; bcd_valid_c flags the final iteration so the result lands on that same edge
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bcd_d       = bcd_q;
      iter_d      = iter_q;
      bcd_valid_c = 1'b0;

      adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
      bcd_c = {adj[BCD_W-2:0], shift_q[DATA_W-1]};

      if (load) begin
         state_d = CONV;
         shift_d = value;
         bcd_d   = '0;
         iter_d  = '0;
      end else begin
         case (state_q)
            IDLE: ;
            CONV: begin
               bcd_d   = bcd_c;
               shift_d = {shift_q[DATA_W-2:0], 1'b0};
               iter_d  = iter_q + ITER_W'(1);
               if (iter_q == ITER_W'(DATA_W - 1)) begin
                  state_d     = IDLE;
                  bcd_valid_c = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/calc_seg_display.sv
// Calculator output stage: latches converted BCD digits and multiplexes them onto the 7-segment pins.
module calc_seg_display
   import calc_disp_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 1024,
   parameter bit          BLANK_LZ    = 1'b1
)(
   input logic               clk,
   input logic               rst,
   calc_seg_display_if.slave bus
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [BCD_W-1:0]      bcd_c;
   logic                  bcd_valid_c;
   logic [BCD_W-1:0]      shown_q;
   logic [CNT_W-1:0]      refresh_q;
   logic [2:0]            idx_q;
   logic [SEG_W-1:0]      seg_q, seg_c;
   logic [NUM_DIGITS-1:0] sel_q, sel_c;
   logic [3:0]            digit_c;
   logic                  blank_c;

   calc_bin2bcd u_bin2bcd (
      .clk         (clk),
      .rst         (rst),
      .load        (bus.load),
      .value       (bus.value),
      .busy        (bus.busy),
      .bcd_c       (bcd_c),
      .bcd_valid_c (bcd_valid_c)
   );

   // Select the scanned digit; a digit above 0 is blank when it and everything above it is zero
   always_comb begin
      digit_c = '0;
      blank_c = 1'b0;
      sel_c   = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == 3'(k)) begin
            digit_c  = shown_q[4*k +: 4];
            blank_c  = BLANK_LZ && (k != 0) && ((shown_q >> (4*k)) == '0);
            sel_c[k] = 1'b0;
         end
      end
      seg_c = blank_c ? SEG_BLANK : seg_lut(digit_c);
   end

   // Shown-digit register and free-running scanner
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shown_q   <= '0;
         refresh_q <= '0;
         idx_q     <= '0;
         seg_q     <= SEG_BLANK;
         sel_q     <= '1;
      end else begin
         if (bcd_valid_c) shown_q <= bcd_c;
         seg_q <= seg_c;
         sel_q <= sel_c;
         if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_q <= '0;
            idx_q     <= (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
         end else begin
            refresh_q <= refresh_q + CNT_W'(1);
         end
      end
   end

   assign bus.seg_out = seg_q;
   assign bus.seg_sel = sel_q;

endmodule

// File: tb/tb_calc_seg_display.sv
// Bench for calc_seg_display: per-cycle comparison against a decimal-arithmetic display model.
module tb_calc_seg_display;

   localparam int unsigned DIV = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   calc_seg_display_if bus ();

   calc_seg_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int         p10 [5]  = '{1, 10, 100, 1000, 10000};

   int         shown, pend, left, edges, last_v;
   bit         m_busy;
   logic [6:0] exp_out;
   logic [4:0] exp_sel;
   logic [6:0] cap [5];
   int         n_assert = 0;
   int         n_fail   = 0;

   function automatic logic [6:0] exp_seg(input int v, input int k);
      if (k > 0 && v < p10[k]) return 7'h7F;
      return lut[(v / p10[k]) % 10];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model of one rising edge: outputs come from the digits held before the edge
   task automatic model_edge();
      int idx;
      idx     = (edges / DIV) % 5;
      exp_sel = ~(5'b00001 << idx);
      exp_out = exp_seg(shown, idx);
      edges++;
      if (bus.load) begin
         pend = int'(bus.value);
         left = 16;
      end else if (left > 0) begin
         left--;
         if (left == 0) shown = pend;
      end
      m_busy = (left > 0);
   endtask

   task automatic model_reset();
      shown = 0; pend = 0; left = 0; edges = 0; m_busy = 1'b0;
   endtask

   task automatic check_all();
      if (!rst) begin
         chk("rst_busy", 32'(bus.busy), 32'd0);
         chk("rst_sel", 32'(bus.seg_sel), 32'h1F);
         chk("rst_seg", 32'(bus.seg_out), 32'h7F);
      end else begin
         chk("busy", 32'(bus.busy), 32'(m_busy));
         chk("seg_sel", 32'(bus.seg_sel), 32'(exp_sel));
         chk("seg_out", 32'(bus.seg_out), 32'(exp_out));
         for (int k = 0; k < 5; k++)
            if (bus.seg_sel == ~(5'b00001 << k)) cap[k] = bus.seg_out;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_edge();
      #1;
      check_all();
   endtask

   task automatic do_load(input int v);
      bus.load  = 1'b1;
      bus.value = 16'(v);
      last_v    = v;
      step();
      bus.load  = 1'b0;
   endtask

   task automatic check_cap(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3, input logic [6:0] e4);
      chk({tag, "_d0"}, 32'(cap[0]), 32'(e0));
      chk({tag, "_d1"}, 32'(cap[1]), 32'(e1));
      chk({tag, "_d2"}, 32'(cap[2]), 32'(e2));
      chk({tag, "_d3"}, 32'(cap[3]), 32'(e3));
      chk({tag, "_d4"}, 32'(cap[4]), 32'(e4));
   endtask

   task automatic settle();
      repeat (17 + 5*DIV) step();
   endtask

   initial begin
      bus.load  = 1'b0;
      bus.value = '0;
      last_v    = 0;
      model_reset();
      for (int k = 0; k < 5; k++) cap[k] = 7'h55;

      // Held in reset
      repeat (3) step();
      rst = 1'b1;
      step();
      chk("first_sel", 32'(bus.seg_sel), 32'h1E);
      chk("first_seg", 32'(bus.seg_out), 32'h40);
      repeat (2*5*DIV) step();

      do_load(12345);
      settle();
      check_cap("v12345", 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);

      do_load(0);
      settle();
      check_cap("v0", 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

      do_load(7);
      settle();
      check_cap("v7", 7'h78, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

      do_load(65535);
      settle();
      check_cap("v65535", 7'h12, 7'h30, 7'h12, 7'h12, 7'h02);

      // Restart while busy: 100 must never reach the display
      do_load(100);
      repeat (7) step();
      do_load(42);
      settle();
      check_cap("v42", 7'h24, 7'h19, 7'h7F, 7'h7F, 7'h7F);

      // Load on the final iteration edge: old result discarded
      do_load(500);
      repeat (15) step();
      do_load(321);
      settle();
      check_cap("v321", 7'h79, 7'h24, 7'h30, 7'h7F, 7'h7F);

      // Random loads with random gaps, some landing mid-conversion
      repeat (25) begin
         do_load(int'($urandom_range(0, 65535)));
         repeat ($urandom_range(0, 24)) step();
      end
      settle();
      check_cap("rand_last", exp_seg(last_v, 0), exp_seg(last_v, 1), exp_seg(last_v, 2),
                exp_seg(last_v, 3), exp_seg(last_v, 4));

      // Reset during busy cycle 10 of a conversion
      do_load(999);
      repeat (9) step();
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_sel", 32'(bus.seg_sel), 32'h1F);
      chk("abort_seg", 32'(bus.seg_out), 32'h7F);
      repeat (2) step();
      rst = 1'b1;
      step();
      chk("rel_sel", 32'(bus.seg_sel), 32'h1E);
      chk("rel_seg", 32'(bus.seg_out), 32'h40);
      repeat (3*5*DIV) step();
      check_cap("after_rst", 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
